// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file.
// Covers both RV32I and RV32E register counts.
package rf_pkg;

  localparam int NREGS_RV32I = 32;
  localparam int NREGS_RV32E = 16;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xdata_t;

  function automatic logic is_x0(input reg_addr_t a);
    return a == 5'd0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A same-cycle allocation outranks a writeback to the same register.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid_i,
  input  logic [AW-1:0]                  alloc_addr_i,
  input  logic [NUM_WR-1:0]              wr_valid_i,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr_i,
  output logic [NREGS-1:0]               busy_o
);

  logic [NREGS-1:0] busy_d, busy_q;
  logic             wb_hit;

  always_comb begin
    busy_d = busy_q;
    wb_hit = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      wb_hit = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_valid_i[w] && wr_addr_i[w] == AW'(r))
          wb_hit = 1'b1;
      end
      if (alloc_valid_i && alloc_addr_i == AW'(r))
        busy_d[r] = 1'b1;
      else if (wb_hit)
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write->read bypass.
// Busy tracking lives in regfile_scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD-1:0][AW-1:0]      i_rd_raddr,
  output logic [NUM_RD-1:0][XLEN-1:0]    o_rd_rdata,
  output logic [NUM_RD-1:0]              o_rd_busy,
  input  logic [NUM_WR-1:0]              i_wr_valid,
  input  logic [NUM_WR-1:0][AW-1:0]      i_wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]    i_wr_data,
  input  logic                           i_alloc_valid,
  input  logic [AW-1:0]                  i_alloc_addr,
  output logic [NREGS-1:0]               o_busy_vec
);

  if (!(NREGS == 16 || NREGS == 32)) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be 16 or 32");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_rd
    $error("regfile_mp: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : g_bad_wr
    $error("regfile_mp: NUM_WR must be 1..2");
  end

  logic [XLEN-1:0] regs_q [NREGS];

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid_i (i_alloc_valid),
    .alloc_addr_i  (i_alloc_addr),
    .wr_valid_i    (i_wr_valid),
    .wr_addr_i     (i_wr_addr),
    .busy_o        (o_busy_vec)
  );

  // Higher write port index is applied last, so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (i_wr_valid[w] && !is_x0(reg_addr_t'(i_wr_addr[w])))
          regs_q[i_wr_addr[w]] <= i_wr_data[w];
      end
    end
  end

  always_comb begin
    o_rd_rdata = '0;
    o_rd_busy  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (!is_x0(reg_addr_t'(i_rd_raddr[p]))) begin
        o_rd_rdata[p] = regs_q[i_rd_raddr[p]];
        o_rd_busy[p]  = o_busy_vec[i_rd_raddr[p]];
        if (BYPASS) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (i_wr_valid[w] && i_wr_addr[w] == i_rd_raddr[p]) begin
              o_rd_rdata[p] = i_wr_data[w];
              o_rd_busy[p]  = i_alloc_valid &&
                              i_alloc_addr == i_rd_raddr[p];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp.
// Two builds: RV32I/bypass and RV32E/no-bypass with 3 read ports.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [2:0][4:0]     raddr;
  logic [1:0]          wv;
  logic [1:0][4:0]     waddr;
  logic [1:0][31:0]    wdata;
  logic                av;
  logic [4:0]          aaddr;

  logic [1:0][4:0]     raddr_a;
  logic [1:0][31:0]    rdata_a;
  logic [1:0]          rbusy_a;
  logic [31:0]         bv_a;

  logic [2:0][3:0]     raddr_b;
  logic [1:0][3:0]     waddr_b;
  logic [3:0]          aaddr_b;
  logic [2:0][31:0]    rdata_b;
  logic [2:0]          rbusy_b;
  logic [15:0]         bv_b;

  assign raddr_a    = {raddr[1], raddr[0]};
  assign raddr_b[0] = raddr[0][3:0];
  assign raddr_b[1] = raddr[1][3:0];
  assign raddr_b[2] = raddr[2][3:0];
  assign waddr_b[0] = waddr[0][3:0];
  assign waddr_b[1] = waddr[1][3:0];
  assign aaddr_b    = aaddr[3:0];

  regfile_mp #(
    .XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .i_rd_raddr(raddr_a), .o_rd_rdata(rdata_a), .o_rd_busy(rbusy_a),
    .i_wr_valid(wv), .i_wr_addr(waddr), .i_wr_data(wdata),
    .i_alloc_valid(av), .i_alloc_addr(aaddr), .o_busy_vec(bv_a)
  );

  regfile_mp #(
    .XLEN(32), .NREGS(16), .NUM_RD(3), .NUM_WR(2), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .i_rd_raddr(raddr_b), .o_rd_rdata(rdata_b), .o_rd_busy(rbusy_b),
    .i_wr_valid(wv), .i_wr_addr(waddr_b), .i_wr_data(wdata),
    .i_alloc_valid(av), .i_alloc_addr(aaddr_b), .o_busy_vec(bv_b)
  );

  // reference state: index 0 = build A (32 regs), 1 = build B (16 regs)
  logic [31:0] mreg [2][32];
  logic        mbusy[2][32];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int na(input int b, input logic [4:0] a);
    return (b == 1) ? int'(a[3:0]) : int'(a);
  endfunction

  task automatic exp_read(input int b, input logic [4:0] ra,
                          output logic [31:0] d, output logic bz);
    int a;
    a = na(b, ra);
    d  = (a == 0) ? 32'h0 : mreg[b][a];
    bz = (a == 0) ? 1'b0 : mbusy[b][a];
    if (b == 0 && a != 0) begin
      if (wv[1] && na(b, waddr[1]) == a) begin
        d = wdata[1]; bz = av && na(b, aaddr) == a;
      end else if (wv[0] && na(b, waddr[0]) == a) begin
        d = wdata[0]; bz = av && na(b, aaddr) == a;
      end
    end
  endtask

  task automatic model_edge();
    for (int b = 0; b < 2; b++) begin
      int n;
      n = (b == 1) ? 16 : 32;
      for (int r = 0; r < n; r++) begin
        if (rst) begin
          mreg[b][r] = '0; mbusy[b][r] = 1'b0;
        end else if (r != 0) begin
          if (wv[1] && na(b, waddr[1]) == r) mreg[b][r] = wdata[1];
          else if (wv[0] && na(b, waddr[0]) == r) mreg[b][r] = wdata[0];
          if (av && na(b, aaddr) == r) mbusy[b][r] = 1'b1;
          else if ((wv[0] && na(b, waddr[0]) == r) ||
                   (wv[1] && na(b, waddr[1]) == r)) mbusy[b][r] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    logic [31:0] d, ev;
    logic bz;
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_read(0, raddr[p], d, bz);
      chk($sformatf("a_rd%0d", p), rdata_a[p], d);
      chk($sformatf("a_bz%0d", p), 32'(rbusy_a[p]), 32'(bz));
    end
    for (int p = 0; p < 3; p++) begin
      exp_read(1, raddr[p], d, bz);
      chk($sformatf("b_rd%0d", p), rdata_b[p], d);
      chk($sformatf("b_bz%0d", p), 32'(rbusy_b[p]), 32'(bz));
    end
    ev = '0;
    for (int r = 0; r < 32; r++) ev[r] = mbusy[0][r];
    chk("a_bvec", bv_a, ev);
    ev = '0;
    for (int r = 0; r < 16; r++) ev[r] = mbusy[1][r];
    chk("b_bvec", 32'(bv_b), ev);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; raddr = '0; wv = '0; waddr = '0;
    wdata = '0; av = 1'b0; aaddr = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 32; r++) begin
        mreg[b][r] = '0; mbusy[b][r] = 1'b0;
      end
    idle();
    #1 chk("init_bvec", bv_a, 32'h0);

    // reset overrides a prior write and concurrent write/alloc
    wv[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'hDEADBEEF;
    step();
    idle(); rst = 1'b1; av = 1'b1; aaddr = 5'd5;
    wv[0] = 1'b1; waddr[0] = 5'd5; wdata[0] = 32'h1;
    step();
    idle(); raddr[0] = 5'd5;
    #1 chk("rst_rd", rdata_a[0], 32'h0);
    chk("rst_bvec", bv_a, 32'h0);
    step();

    // x0 is hardwired
    idle(); wv[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'h1234;
    av = 1'b1; aaddr = 5'd0;
    #1 chk("x0_same", rdata_a[0], 32'h0);
    chk("x0_busy", 32'(rbusy_a[0]), 32'h0);
    step();
    idle();
    #1 chk("x0_next", rdata_a[0], 32'h0);
    chk("x0_bvec", bv_a, 32'h0);
    step();

    // bypass vs registered read
    wv[0] = 1'b1; waddr[0] = 5'd7; wdata[0] = 32'h11111111;
    step();
    wdata[0] = 32'hA5A5A5A5; raddr[0] = 5'd7;
    #1 chk("byp_a", rdata_a[0], 32'hA5A5A5A5);
    chk("nobyp_b", rdata_b[0], 32'h11111111);
    step();
    idle(); raddr[0] = 5'd7;
    #1 chk("nobyp_b_next", rdata_b[0], 32'hA5A5A5A5);
    step();

    // write collision: port 1 wins
    idle(); wv = 2'b11; waddr[0] = 5'd3; waddr[1] = 5'd3;
    wdata[0] = 32'h1; wdata[1] = 32'h2; raddr[1] = 5'd3;
    #1 chk("col_byp", rdata_a[1], 32'h2);
    step();
    idle(); raddr[1] = 5'd3;
    #1 chk("col_a", rdata_a[1], 32'h2);
    chk("col_b", rdata_b[1], 32'h2);
    step();

    // scoreboard priority
    idle(); av = 1'b1; aaddr = 5'd9;
    step();
    idle(); raddr[0] = 5'd9;
    #1 chk("sb_alloc", 32'(rbusy_a[0]), 32'h1);
    av = 1'b1; aaddr = 5'd9;
    wv[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h77;
    step();
    idle(); raddr[0] = 5'd9;
    #1 chk("sb_keep", 32'(bv_a[9]), 32'h1);
    wv[0] = 1'b1; waddr[0] = 5'd9; wdata[0] = 32'h99;
    step();
    idle(); raddr[0] = 5'd9;
    #1 chk("sb_clear", 32'(bv_a[9]), 32'h0);
    chk("sb_data", rdata_a[0], 32'h99);
    step();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int p = 0; p < 3; p++)
        raddr[p] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                       : 5'($urandom_range(0, 31));
      for (int w = 0; w < 2; w++) begin
        wv[w]    = $urandom_range(0, 1);
        waddr[w] = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                       : 5'($urandom_range(0, 31));
        wdata[w] = $urandom;
      end
      av    = $urandom_range(0, 1);
      aaddr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7))
                                   : 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
